// File: rtl/core_pkg.sv
// Shared core constants: datapath width, register addressing, the ebreak
// encoding checked by writeback, and the opcodes shared with decode/memory.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int REG_A0 = 10;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    function automatic logic is_ebreak(input logic [31:0] instr);
        return instr == INSTR_EBREAK;
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback bus: retiring instruction and read requests from the pipeline,
// operand data, commit trace, counters and halt status back to it.
interface writeback_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             valid;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic             RegWrite;
    logic [XLEN-1:0]  MEMORY_OUT;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  REG_VALUE_OUT1;
    logic [XLEN-1:0]  REG_VALUE_OUT2;
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
    logic             halted;
    logic [XLEN-1:0]  halt_code;

    modport master (
        output valid, instr, pc, RegWrite, MEMORY_OUT, rs1_addr, rs2_addr,
        input  REG_VALUE_OUT1, REG_VALUE_OUT2, commit_valid, commit_pc,
               cycle_cnt, instret_cnt, halted, halt_code
    );

    modport slave (
        input  valid, instr, pc, RegWrite, MEMORY_OUT, rs1_addr, rs2_addr,
        output REG_VALUE_OUT1, REG_VALUE_OUT2, commit_valid, commit_pc,
               cycle_cnt, instret_cnt, halted, halt_code
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with x0 forced to zero and a
// write-through bypass so a same-cycle read sees the value being written.
module regfile_2r1w
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    output logic [XLEN-1:0]   a0_value
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
    end

    // The halt code is sampled from storage, never from the bypass path.
    assign a0_value = regs[REG_A0];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: commits results to the register file, keeps cycle and
// instret counters, reports the commit trace and latches halt on ebreak.
module writeback_regfile
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    writeback_regfile_if.slave bus
);

    logic [REG_AW-1:0] rd;
    logic              ebreak_retire;
    logic              we;
    logic [XLEN-1:0]   a0_value;
    logic              halted;
    logic [XLEN-1:0]   halt_code;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instret_cnt;
    logic              commit_valid;
    logic [31:0]       commit_pc;

    assign rd            = bus.instr[11:7];
    assign ebreak_retire = bus.valid && is_ebreak(bus.instr);
    assign we            = bus.valid && bus.RegWrite && !halted &&
                           (rd != '0) && !ebreak_retire;

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (rd),
        .wdata    (bus.MEMORY_OUT),
        .raddr1   (bus.rs1_addr),
        .raddr2   (bus.rs2_addr),
        .rdata1   (bus.REG_VALUE_OUT1),
        .rdata2   (bus.REG_VALUE_OUT2),
        .a0_value (a0_value)
    );

    // Everything except the commit trace freezes once halted is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted       <= 1'b0;
            halt_code    <= '0;
            cycle_cnt    <= '0;
            instret_cnt  <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else begin
            commit_valid <= bus.valid && !halted;
            commit_pc    <= bus.pc;
            if (!halted) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                if (bus.valid) begin
                    instret_cnt <= instret_cnt + CNT_W'(1);
                end
                if (ebreak_retire) begin
                    halted    <= 1'b1;
                    halt_code <= a0_value;
                end
            end
        end
    end

    assign bus.halted       = halted;
    assign bus.halt_code    = halt_code;
    assign bus.cycle_cnt    = cycle_cnt;
    assign bus.instret_cnt  = instret_cnt;
    assign bus.commit_valid = commit_valid;
    assign bus.commit_pc    = commit_pc;

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage of the single-cycle core. It takes the memory stage's selected result (ALU or load data) and commits it to a 32×32 integer register file. It serves the two combinational operand reads for decode/execute, keeps 64-bit cycle and retired-instruction counters, and latches a halt on `ebreak` so the simulation harness can stop and read the exit code.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `NREG`, 32: architectural registers; x0 hardwired to zero.
- `CNT_W`, 64: width of the cycle and instret counters.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `valid`, in, 1: the instruction on `instr` retires this cycle.
- `instr`, in, 32: current instruction; `rd` = `instr[11:7]`.
- `pc`, in, 32: PC of the current instruction.
- `RegWrite`, in, 1: write `MEMORY_OUT` to `rd`.
- `MEMORY_OUT`, in, XLEN: writeback data from the memory stage.
- `rs1_addr`, in, 5: read port 1 address.
- `rs2_addr`, in, 5: read port 2 address.
- `REG_VALUE_OUT1`, out, XLEN: read port 1 data, combinational.
- `REG_VALUE_OUT2`, out, XLEN: read port 2 data, combinational.
- `commit_valid`, out, 1: registered; an instruction retired in the previous cycle.
- `commit_pc`, out, 32: registered PC of that instruction.
- `cycle_cnt`, out, CNT_W: cycles since reset, counted while not halted.
- `instret_cnt`, out, CNT_W: instructions retired.
- `halted`, out, 1: sticky; set after `ebreak` retires.
- `halt_code`, out, XLEN: value of x10 (a0) when `ebreak` retired.

## Operation
- Write enable: `we = valid & RegWrite & ~halted & (rd != 0)`. On a clock edge with `we`, `regs[rd] <= MEMORY_OUT`.
- Reads:
  - Address 0 returns 0.
  - If `we` and the read address equals `rd`, the port returns `MEMORY_OUT` (write-through bypass).
  - Otherwise the port returns `regs[addr]`.
  - Both ports apply the bypass independently, including when `rs1_addr == rs2_addr == rd`.
- Halt detection:
  - `ebreak` is recognised only when `instr == 32'h0010_0073` and `valid` is high.
  - On that edge: `halted <= 1` and `halt_code <= regs[10]`. `ebreak` itself never writes the register file.
  - Once halted, all writes, both counters and `commit_valid` freeze. Only reset clears `halted`.
- Counters:
  - `cycle_cnt` increments by 1 on every edge while `~halted`.
  - `instret_cnt` increments by 1 on every edge with `valid & ~halted`; the `ebreak` itself counts.
  - Both counters wrap modulo 2^CNT_W with no saturation.
- Commit trace: `commit_valid <= valid & ~halted` and `commit_pc <= pc`; the `ebreak` commit is reported.
- Reset (`rst` low, takes effect immediately, independent of `clk`):
  - `regs[*] = 0`, `cycle_cnt = 0`, `instret_cnt = 0`, `halted = 0`, `halt_code = 0`, `commit_valid = 0`, `commit_pc = 0`.
  - Read ports then return 0 for all addresses.
  - Assertion mid-write discards that write.

## Timing
- Write latency: 1 edge. Reads are zero-latency combinational; the bypass covers same-cycle read-after-write.
- `halted` rises on the edge where `ebreak` retires. `halt_code` is valid from that same edge.
- `commit_valid` and `commit_pc` lag the retiring instruction by exactly one cycle.
- Deassertion of `rst` is synchronised externally. The first edge with `rst` high counts as `cycle_cnt` = 1.
- No internal combinational path from `MEMORY_OUT` to any registered output other than `regs`.

## Structure
- Shared package `core_pkg`:
  - `XLEN`, `REG_AW` = 5.
  - `INSTR_EBREAK` = `32'h0010_0073`.
  - `REG_A0` = 10.
  - Opcode constants shared with decode and memory.
- One sub-module, `regfile_2r1w`: storage, x0 masking and the write-through bypass.
- Halt logic, counters and the commit trace stay in the top level.

## Test plan
- After reset, write x5 = `0xDEADBEEF`, then read `rs1_addr` = 5 on the next cycle -> `REG_VALUE_OUT1` = `0xDEADBEEF`.
- Write x0 = `0x1234` with `RegWrite` = 1 -> reads of x0 return 0; `instret_cnt` still increments.
- Same cycle: `we` to x7 = `0xA5A5A5A5` with `rs1_addr` = `rs2_addr` = 7 -> both ports show `0xA5A5A5A5` in that cycle; the old value is not visible.
- Set x10 = 42, then retire `ebreak` -> `halted` = 1 and `halt_code` = 42. A subsequent write of x3 = 9 is ignored (x3 keeps its prior value), and both counters stop at their post-ebreak values.
- Retire 5 instructions with `valid` low on 2 cycles in between -> `cycle_cnt` = 7 and `instret_cnt` = 5; `commit_pc` tracks each retired PC one cycle later.
- Assert `rst` low asynchronously mid-cycle after x1 = 1 -> all outputs 0 immediately; `halted` = 0 and x1 reads 0 after release.
